comp_seq: RTL and testbench
===========================

COMP_SEQ -- requirements
Module: comp_seq

Interface
Parameters:
REQ-001 SHALL provide parameter WIDTH, default 16, operand width in bits; must be even and >= 2; any other value SHALL be an elaboration error.
REQ-002 SHALL provide parameter SIGNED_EN, default 1; 1 enables two's-complement mode, 0 ties signed_mode internally to 0.

Ports (name direction width meaning):
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to compare; sampled only in IDLE.
REQ-006 A  input  WIDTH  operand A; captured on accepted start.
REQ-007 B  input  WIDTH  operand B; captured on accepted start.
REQ-008 signed_mode  input  1  1 = two's-complement compare; captured on accepted start.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 EQ  output  1  A == B (registered).
REQ-012 GT  output  1  A > B (registered).
REQ-013 LT  output  1  A < B (registered).

Function
REQ-014 SHALL implement FSM with states IDLE, RUN, DONE.
REQ-015 IDLE, start=1: SHALL capture A, B and signed_mode; load digit index = WIDTH/2-1 (MSB digit); go to RUN. IDLE, start=0: stay.
REQ-016 RUN: SHALL compare one 2-bit digit per cycle, {A[2i+1:2i]} vs {B[2i+1:2i]}, MSB digit first.
REQ-017 Signed mode: for the MSB digit only, SHALL invert bit WIDTH-1 of both operands before comparing; all other digits unsigned.
REQ-018 RUN, digits differ: SHALL set GT = (digitA > digitB), LT = !GT, EQ = 0; go to DONE (early termination; remaining digits not examined).
REQ-019 RUN, digits equal, index > 0: SHALL decrement index; stay in RUN.
REQ-020 RUN, digits equal, index = 0: SHALL set EQ=1, GT=0, LT=0; go to DONE.
REQ-021 DONE: done SHALL be 1 for exactly this one cycle; next state IDLE.
REQ-022 Latency: with k digits examined (1 <= k <= WIDTH/2), done SHALL be high in the (k+1)th cycle after the edge that accepted start.
REQ-023 EQ/GT/LT SHALL be updated only on entry to DONE and held stable until the next update or reset; exactly one of them SHALL be 1 after any completed compare.
REQ-024 start in RUN or DONE SHALL be ignored (not queued); A/B/signed_mode changes after capture SHALL not affect the result.
REQ-025 start held high continuously SHALL cause back-to-back compares: accepted in IDLE in the cycle after DONE.
REQ-026 Captured operands SHALL be held in internal registers; no combinational path from A, B, start to any output.

Reset
REQ-027 reset=1 at a rising edge SHALL force state IDLE, busy=0, done=0, EQ=0, GT=0, LT=0, index=WIDTH/2-1, regardless of state (including mid-RUN).
REQ-028 reset SHALL take priority over start in the same cycle; start is not accepted.
REQ-029 After reset deasserts, the first start SHALL be accepted normally; no partial result from an aborted compare SHALL appear.

Verification (WIDTH=8)
REQ-030 Unsigned equal: A=0xA5, B=0xA5, signed_mode=0, start pulse -> busy for 5 cycles, done in cycle 5 after accept, EQ=1 GT=0 LT=0.
REQ-031 Early exit: A=0x80, B=0x7F, signed_mode=0 -> done in cycle 2, GT=1; same operands, signed_mode=1 -> done in cycle 2, LT=1.
REQ-032 Late difference: A=0x12, B=0x13, signed_mode=1 -> 4 digits examined, done in cycle 5, LT=1; A=0xFF (-1), B=0xFE (-2) signed -> GT=1, done in cycle 5.
REQ-033 Start while busy: A=0x00,B=0x00 accepted; pulse start with A=0xFF mid-RUN -> ignored, EQ=1; next start after return to IDLE accepted.
REQ-034 Reset mid-operation: assert reset in 2nd RUN cycle of a compare -> next cycle busy=0, done=0, EQ=GT=LT=0; no done pulse follows; subsequent compare A=0x03,B=0x01 -> GT=1.
REQ-035 Continuous start high over 3 compares -> done pulses spaced exactly (k+2) cycles apart, each result matching its captured operands.

Source files
------------

// File: rtl/comp_seq.sv
// Sequential magnitude comparator: walks the captured operands one 2-bit digit per
// cycle from the most significant end and stops at the first differing digit.
module comp_seq #(
   parameter int WIDTH     = 16,
   parameter int SIGNED_EN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             EQ,
   output logic             GT,
   output logic             LT
);

   localparam int DIGITS = WIDTH / 2;
   localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] MSB_IDX  = IW'(DIGITS - 1);
   localparam logic [IW-1:0] IDX_ZERO = IW'(0);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic          SIGNED_OK = (SIGNED_EN != 0);

   generate
      if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
         $error("comp_seq: WIDTH must be even and >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r, state_s;
   logic [WIDTH-1:0] a_r, a_s;
   logic [WIDTH-1:0] b_r, b_s;
   logic             sgn_r, sgn_s;
   logic [IW-1:0]    idx_r, idx_s;
   logic             eq_r, eq_s;
   logic             gt_r, gt_s;
   logic             lt_r, lt_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;
   logic             flip_s;
   logic [1:0]       digit_a_s;
   logic [1:0]       digit_b_s;

   // Next-state, operand capture and result computation.
   always_comb begin
      state_s = state_r;
      a_s     = a_r;
      b_s     = b_r;
      sgn_s   = sgn_r;
      idx_s   = idx_r;
      eq_s    = eq_r;
      gt_s    = gt_r;
      lt_s    = lt_r;

      // In signed mode the sign bits are inverted so the top digit orders like unsigned.
      flip_s    = sgn_r & (idx_r == MSB_IDX);
      digit_a_s = a_r[{idx_r, 1'b0} +: 2] ^ {flip_s, 1'b0};
      digit_b_s = b_r[{idx_r, 1'b0} +: 2] ^ {flip_s, 1'b0};

      case (state_r)
         IDLE: begin
            if (start) begin
               a_s     = A;
               b_s     = B;
               sgn_s   = signed_mode & SIGNED_OK;
               idx_s   = MSB_IDX;
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (digit_a_s != digit_b_s) begin
               gt_s    = (digit_a_s > digit_b_s);
               lt_s    = (digit_a_s < digit_b_s);
               eq_s    = 1'b0;
               state_s = DONE;
            end else if (idx_r == IDX_ZERO) begin
               eq_s    = 1'b1;
               gt_s    = 1'b0;
               lt_s    = 1'b0;
               state_s = DONE;
            end else begin
               idx_s   = idx_r - IDX_ONE;
               state_s = RUN;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      busy_s = (state_s == RUN) || (state_s == DONE);
      done_s = (state_s == DONE);
   end

   // State, operand and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         sgn_r   <= 1'b0;
         idx_r   <= MSB_IDX;
         eq_r    <= 1'b0;
         gt_r    <= 1'b0;
         lt_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         a_r     <= a_s;
         b_r     <= b_s;
         sgn_r   <= sgn_s;
         idx_r   <= idx_s;
         eq_r    <= eq_s;
         gt_r    <= gt_s;
         lt_r    <= lt_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign EQ   = eq_r;
   assign GT   = gt_r;
   assign LT   = lt_r;

endmodule

// File: tb/tb_comp_seq.sv
// Self-checking bench for comp_seq at WIDTH=8 against an arithmetic reference model.
module tb_comp_seq;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic       signed_mode;
   logic       busy;
   logic       done;
   logic       EQ;
   logic       GT;
   logic       LT;

   int checks   = 0;
   int failures = 0;

   comp_seq #(.WIDTH(8), .SIGNED_EN(1)) dut (
      .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
      .signed_mode(signed_mode), .busy(busy), .done(done),
      .EQ(EQ), .GT(GT), .LT(LT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: digits examined = digits down to and including the highest differing one.
   function automatic void ref_cmp(input logic [7:0] a, input logic [7:0] b, input logic s,
                                   output int k, output logic eq, output logic gt,
                                   output logic lt);
      logic [7:0] diff;
      int top;
      diff = a ^ b;
      top  = -1;
      for (int i = 0; i < 4; i++) begin
         if (((diff >> (2 * i)) & 8'd3) != 8'd0) top = i;
      end
      k  = (top < 0) ? 4 : 4 - top;
      eq = (a == b);
      gt = s ? ($signed(a) > $signed(b)) : (a > b);
      lt = !eq && !gt;
   endfunction

   // Presents a start in IDLE; returns 1 time unit after the accepting edge (cycle 1).
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
      @(negedge clk);
      A = a; B = b; signed_mode = s; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = 8'($urandom); B = 8'($urandom); signed_mode = 1'($urandom);
   endtask

   // Polls from cycle 1 until done; leaves the DUT back in IDLE.
   task automatic wait_done(output int lat, output int busy_cnt, output bit timeout);
      lat = 1; busy_cnt = 0; timeout = 1'b0;
      forever begin
         if (busy) busy_cnt++;
         if (done) break;
         if (lat >= 20) begin timeout = 1'b1; break; end
         @(posedge clk);
         #1;
         lat++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic compare_and_check(input string name, input logic [7:0] a,
                                    input logic [7:0] b, input logic s);
      int k, lat, bc;
      bit to;
      logic eq, gt, lt;
      ref_cmp(a, b, s, k, eq, gt, lt);
      issue(a, b, s);
      wait_done(lat, bc, to);
      checks++;
      if (to !== 1'b0 || lat !== k + 1) begin
         failures++;
         $display("FAIL %s latency: got %0d (timeout=%0d) expected %0d", name, lat, to, k + 1);
      end
      checks++;
      if (bc !== k + 1) begin
         failures++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, k + 1);
      end
      checks++;
      if ({EQ, GT, LT} !== {eq, gt, lt}) begin
         failures++;
         $display("FAIL %s flags: got EQ/GT/LT=%b expected %b (A=%h B=%h s=%0d)",
                  name, {EQ, GT, LT}, {eq, gt, lt}, a, b, s);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; A = 8'h12; B = 8'h34; signed_mode = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({busy, done, EQ, GT, LT} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_state: got busy/done/EQ/GT/LT=%b expected 00000",
                     {busy, done, EQ, GT, LT});
         end
      end
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_directed();
      compare_and_check("uns_equal_A5", 8'hA5, 8'hA5, 1'b0);
      compare_and_check("early_uns_80_7F", 8'h80, 8'h7F, 1'b0);
      compare_and_check("early_sgn_80_7F", 8'h80, 8'h7F, 1'b1);
      compare_and_check("late_sgn_12_13", 8'h12, 8'h13, 1'b1);
      compare_and_check("late_sgn_FF_FE", 8'hFF, 8'hFE, 1'b1);
      compare_and_check("sgn_equal_80", 8'h80, 8'h80, 1'b1);
   endtask

   task automatic test_start_while_busy();
      int lat, bc;
      bit to;
      issue(8'h00, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      start = 1'b1; A = 8'hFF; B = 8'h00;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 3; bc = 0; to = 1'b0;
      while (!done && !to) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat > 20) to = 1'b1;
      end
      checks++;
      if (to !== 1'b0 || lat !== 5) begin
         failures++;
         $display("FAIL busy_start_latency: got %0d (timeout=%0d) expected 5", lat, to);
      end
      checks++;
      if ({EQ, GT, LT} !== 3'b100) begin
         failures++;
         $display("FAIL busy_start_ignored: got EQ/GT/LT=%b expected 100", {EQ, GT, LT});
      end
      @(posedge clk);
      #1;
      compare_and_check("after_busy_FF_00", 8'hFF, 8'h00, 1'b0);
   endtask

   task automatic test_reset_mid();
      bit saw_done;
      compare_and_check("pre_reset_C0_01", 8'hC0, 8'h01, 1'b0);
      issue(8'h00, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({busy, done, EQ, GT, LT} !== 5'b00000) begin
         failures++;
         $display("FAIL reset_mid_run: got busy/done/EQ/GT/LT=%b expected 00000",
                  {busy, done, EQ, GT, LT});
      end
      reset = 1'b0;
      start = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_stale_done: got activity=%0d expected 0", saw_done);
      end
      compare_and_check("post_reset_03_01", 8'h03, 8'h01, 1'b0);
   endtask

   task automatic test_random();
      logic [7:0] a, b;
      logic s;
      for (int n = 0; n < 40; n++) begin
         a = 8'($urandom);
         b = ($urandom_range(0, 3) == 0) ? (a ^ 8'($urandom_range(0, 3))) : 8'($urandom);
         s = 1'($urandom);
         compare_and_check("random", a, b, s);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] oa [3];
      logic [7:0] ob [3];
      logic       os [3];
      int n, t, last_t, k;
      logic eq, gt, lt;
      for (int i = 0; i < 3; i++) begin
         oa[i] = 8'($urandom); ob[i] = 8'($urandom); os[i] = 1'($urandom);
      end
      ob[1] = oa[1] ^ 8'h01;
      n = 0; t = 0; last_t = 0;
      @(negedge clk);
      A = oa[0]; B = ob[0]; signed_mode = os[0]; start = 1'b1;
      while (n < 3 && t < 60) begin
         @(posedge clk);
         #1;
         t++;
         if (done) begin
            ref_cmp(oa[n], ob[n], os[n], k, eq, gt, lt);
            checks++;
            if ({EQ, GT, LT} !== {eq, gt, lt}) begin
               failures++;
               $display("FAIL b2b_flags[%0d]: got %b expected %b", n, {EQ, GT, LT}, {eq, gt, lt});
            end
            checks++;
            if ((n == 0 && t !== k + 1) || (n > 0 && t - last_t !== k + 2)) begin
               failures++;
               $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", n,
                        (n == 0) ? t : t - last_t, (n == 0) ? k + 1 : k + 2);
            end
            last_t = t;
            n++;
            if (n < 3) begin
               A = oa[n]; B = ob[n]; signed_mode = os[n];
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      checks++;
      if (n !== 3) begin
         failures++;
         $display("FAIL b2b_count: got %0d done pulses expected 3", n);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; signed_mode = 1'b0;
      test_reset();
      test_directed();
      test_start_while_busy();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
